// File: rtl/tpu_controller.sv
// tpu_controller: sequencer for the 2x2 systolic MMU path.
// Holds the host-written weight/input stores, steps the feeder through one
// matrix-multiply pass per start command and tags the streamed results.
// Optional pass counter output guarded by macro TPU_CTRL_PASSCNT_EN.
module tpu_controller #(
    parameter int unsigned NUM_CYCLES = 6,
    parameter int unsigned FIRST_OUT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] host_wdata,
    input  logic [2:0] host_waddr,
    input  logic       host_wvalid,
    input  logic       start,
    output logic       busy,
    output logic       wr_err,
    input  logic       err_clr,
    output logic       pass_done,
    output logic       out_valid,
    output logic [1:0] out_idx,
    output logic       feed_en,
    output logic [2:0] mmu_cycle,
    input  logic       feed_done,
    output logic [7:0] weight0,
    output logic [7:0] weight1,
    output logic [7:0] weight2,
    output logic [7:0] weight3,
    output logic [7:0] input0,
    output logic [7:0] input1,
    output logic [7:0] input2,
    output logic [7:0] input3
`ifdef TPU_CTRL_PASSCNT_EN
    ,
    output logic [7:0] pass_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [2:0] LastCycle = 3'(NUM_CYCLES - 1);
    localparam logic [2:0] FirstOut  = 3'(FIRST_OUT);
    localparam logic [3:0] EndOut    = 4'(FIRST_OUT + 4);

    state_e     state_q, state_d;
    logic       feed_en_q, feed_en_d;
    logic [2:0] cycle_q, cycle_d;
    logic       pass_done_q, pass_done_d;
    logic       wr_err_q, wr_err_d;
    logic [7:0] store_q [8];
    logic       in_window;

    // Host byte store; writes only land while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                store_q[i] <= 8'd0;
            end
        end else if (host_wvalid && (state_q == StIdle)) begin
            store_q[host_waddr] <= host_wdata;
        end
    end

    // Sequencer state and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            feed_en_q   <= 1'b0;
            cycle_q     <= 3'd0;
            pass_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            feed_en_q   <= feed_en_d;
            cycle_q     <= cycle_d;
            pass_done_q <= pass_done_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Next-state logic; start on the final cycle chains straight into a new pass.
    always_comb begin
        state_d     = state_q;
        feed_en_d   = feed_en_q;
        cycle_d     = cycle_q;
        pass_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    feed_en_d = 1'b1;
                    cycle_d   = 3'd0;
                end
            end
            StRun: begin
                if (cycle_q == LastCycle) begin
                    pass_done_d = 1'b1;
                    cycle_d     = 3'd0;
                    if (start) begin
                        state_d   = StRun;
                        feed_en_d = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        feed_en_d = 1'b0;
                    end
                end else begin
                    cycle_d = cycle_q + 3'd1;
                end
            end
            default: begin
                state_d   = StIdle;
                feed_en_d = 1'b0;
                cycle_d   = 3'd0;
            end
        endcase
    end

    // Sticky write error; a new set beats a simultaneous clear.
    always_comb begin
        wr_err_d = wr_err_q;
        if (err_clr) begin
            wr_err_d = 1'b0;
        end
        if (host_wvalid && (state_q == StRun)) begin
            wr_err_d = 1'b1;
        end
    end

    // Result tagging, masked by the feeder's own done flag.
    always_comb begin
        in_window = (cycle_q >= FirstOut) && ({1'b0, cycle_q} < EndOut);
        out_valid = feed_en_q && feed_done && in_window;
        out_idx   = out_valid ? 2'(cycle_q - FirstOut) : 2'd0;
    end

`ifdef TPU_CTRL_PASSCNT_EN
    logic [7:0] pass_cnt_q;

    // Completed-pass counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= 8'd0;
        end else if (pass_done_d) begin
            pass_cnt_q <= pass_cnt_q + 8'd1;
        end
    end

    assign pass_cnt = pass_cnt_q;
`endif

    assign busy      = (state_q == StRun);
    assign wr_err    = wr_err_q;
    assign pass_done = pass_done_q;
    assign feed_en   = feed_en_q;
    assign mmu_cycle = cycle_q;
    assign weight0   = store_q[0];
    assign weight1   = store_q[1];
    assign weight2   = store_q[2];
    assign weight3   = store_q[3];
    assign input0    = store_q[4];
    assign input1    = store_q[5];
    assign input2    = store_q[6];
    assign input3    = store_q[7];

endmodule
